// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: instruction word type,
// fetch FSM state encoding and the NOP encoding loaded into instr_raw at reset.
package fetch_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HOLD  = 3'd4,
        S_FAULT = 3'd5
    } fetch_state_e;

    // addi x0, x0, 0
    localparam instr_t NOP_INSTR = 32'h0000_0013;

    // Clears the two low address bits so a target is always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch unit: issues one-cycle reads to instruction memory, waits
// (bounded by MAX_WAIT) for the ack, and presents pc/instr_raw to decode with
// a one-cycle enabled pulse. Redirects landing while a read is in flight mark
// that read stale so its data is dropped and the target is fetched instead.
// Optional build macro: FETCH_MISALIGN_CHECK_EN -- when defined, an accepted
// redirect whose target is not word aligned sends the unit to S_FAULT;
// otherwise the target's low two bits are cleared.
//
// Handshake: imem_req is a single-cycle request with imem_addr valid in the
// same cycle; imem_ack/imem_rdata are only looked at in S_WAIT, so the
// earliest usable ack is the cycle after imem_req. Downstream sees new data
// exactly when enabled=1 and requests more by raising next while in S_HOLD.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         next,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  pc,
    output instr_t       instr_raw,
    output logic         enabled,
    output logic         fault,
    output fetch_state_e dbg_state
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    fetch_state_e   state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    pc_q, pc_d;
    instr_t         instr_q, instr_d;
    logic           pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [CW-1:0]  cnt_inc;
    logic [31:0]    redir_tgt;
    logic           redir_bad;
    logic           redir_acc;

    assign cnt_inc = cnt_q + CW'(1);

    // Redirect target conditioning and whether this state accepts a redirect.
    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        redir_tgt = redirect_pc;
        redir_bad = (redirect_pc[1:0] != 2'b00);
`else
        redir_tgt = align_word(redirect_pc);
        redir_bad = 1'b0;
`endif
        redir_acc = redirect && ((state_q == S_REQ)   || (state_q == S_WAIT) ||
                                 (state_q == S_ISSUE) || (state_q == S_HOLD));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; a rejected (misaligned) redirect overrides all.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = (pend_q || redirect) ? S_REQ : S_ISSUE;
                end else if (cnt_inc == CW'(MAX_WAIT)) begin
                    state_d = S_FAULT;
                end
            end
            S_ISSUE: state_d = redirect ? S_REQ : S_HOLD;
            S_HOLD:  if (redirect || next) state_d = S_REQ;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (redir_acc && redir_bad) state_d = S_FAULT;
    end

    // FSM outputs: pure decodes of the current state.
    always_comb begin
        imem_req = (state_q == S_REQ);
        enabled  = (state_q == S_ISSUE);
        fault    = (state_q == S_FAULT);
    end

    // Datapath next values: fetch address, issued pc/word, stale flag, timer.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_REQ: begin
                cnt_d = '0;
                if (redirect) begin
                    pend_d     = 1'b1;
                    fetch_pc_d = redir_tgt;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (pend_q || redirect) begin
                        pend_d = 1'b0;
                        if (redirect) fetch_pc_d = redir_tgt;
                    end else begin
                        pc_d       = fetch_pc_q;
                        instr_d    = imem_rdata;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (redirect) begin
                        pend_d     = 1'b1;
                        fetch_pc_d = redir_tgt;
                    end
                end
            end
            S_ISSUE, S_HOLD: begin
                if (redirect) fetch_pc_d = redir_tgt;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_VECTOR;
            pc_q       <= 32'h0000_0000;
            instr_q    <= NOP_INSTR;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign pc        = pc_q;
    assign instr_raw = instr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch unit: a default instance (RESET_VECTOR=0)
// exercises fetch, redirect, timeout and reset cases; a second instance with
// RESET_VECTOR=32'hFFFF_FFFC covers the address wrap.
module tb_fetch;
    import fetch_pkg::*;

    localparam int MW = 255;

    int checks = 0;
    int errors = 0;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn = 1'b0;
    logic        next = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    instr_t      instr_raw;
    logic        enabled;
    logic        fault;
    fetch_state_e dbg_state;

    logic        w_rstn = 1'b0;
    logic        w_next = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_ack = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_pc;
    instr_t      w_instr_raw;
    logic        w_enabled;
    logic        w_fault;
    fetch_state_e w_dbg_state;

    fetch #(.RESET_VECTOR(32'h0000_0000), .MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn), .next(next), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .instr_raw(instr_raw), .enabled(enabled), .fault(fault),
        .dbg_state(dbg_state)
    );

    fetch #(.RESET_VECTOR(32'hFFFF_FFFC), .MAX_WAIT(MW)) dut_wrap (
        .clk(clk), .rstn(w_rstn), .next(w_next), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .pc(w_pc),
        .instr_raw(w_instr_raw), .enabled(w_enabled), .fault(w_fault),
        .dbg_state(w_dbg_state)
    );

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: called in the S_REQ cycle, answers the read lat cycles later.
    task automatic mem_return(input int lat, input logic [31:0] data);
        repeat (lat) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, S_IDLE); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL rst_enabled got %b exp 0", enabled); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
        checks++; if (instr_raw !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr_raw); end
    endtask

    task automatic test_basic_fetch();
        rstn = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr got %h exp 0", imem_addr); end
        mem_return(2, 32'h0010_0093);
        checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL basic_enabled got %b exp 1", enabled); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL basic_pc got %h exp 0", pc); end
        checks++; if (instr_raw !== 32'h0010_0093) begin errors++; $display("FAIL basic_instr got %h exp 00100093", instr_raw); end
        tick();
        checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL basic_pulse_once got %b exp 0", enabled); end
        repeat (3) tick();
        checks++; if (dbg_state !== S_HOLD) begin errors++; $display("FAIL basic_hold got %0d exp %0d", dbg_state, S_HOLD); end
        checks++; if (instr_raw !== 32'h0010_0093) begin errors++; $display("FAIL basic_hold_instr got %h exp 00100093", instr_raw); end
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_next_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got %h exp 00000004", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL rw_drop_enabled got %b exp 0", enabled); end
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL rw_addr got %h/%b exp 00000100/1", imem_addr, imem_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rw_pc_kept got %h exp 0", pc); end
        mem_return(1, 32'h0020_0113);
        checks++; if (enabled !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL rw_issue got %b/%h exp 1/00000100", enabled, pc); end
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL rw_same_enabled got %b exp 0", enabled); end
        checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL rw_same_addr got %h/%b exp 00000200/1", imem_addr, imem_req); end
        mem_return(1, 32'h0030_0193);
        checks++; if (pc !== 32'h200 || instr_raw !== 32'h0030_0193) begin errors++; $display("FAIL rw_same_issue got %h/%h exp 00000200/00300193", pc, instr_raw); end
        tick();
    endtask

    task automatic test_redirect_next();
        next = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        next = 1'b0; redirect = 1'b0;
        checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL rn_addr got %h/%b exp 00000040/1", imem_addr, imem_req); end
        mem_return(3, 32'h0040_0213);
        checks++; if (enabled !== 1'b1 || pc !== 32'h40) begin errors++; $display("FAIL rn_issue got %b/%h exp 1/00000040", enabled, pc); end
        redirect = 1'b1; redirect_pc = 32'h0000_0080;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h80 || imem_req !== 1'b1 || enabled !== 1'b0) begin errors++; $display("FAIL ri_addr got %h/%b/%b exp 00000080/1/0", imem_addr, imem_req, enabled); end
        mem_return(1, 32'h0000_0013);
        tick();
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b exp 1", fault); end
`else
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL mis_addr got %h/%b/%b exp 00000100/1/0", imem_addr, imem_req, fault); end
`endif
    endtask

    task automatic test_reset_mid();
        rstn = 1'b0;
        #1;
        checks++; if (dbg_state !== S_IDLE || imem_addr !== 32'h0 || pc !== 32'h0 || instr_raw !== 32'h0000_0013) begin
            errors++; $display("FAIL async_rst got %0d/%h/%h/%h exp 0/0/0/00000013", dbg_state, imem_addr, pc, instr_raw);
        end
        tick();
        rstn = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        checks++; if (dbg_state !== S_IDLE || imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst got %0d/%b exp 0/0", dbg_state, imem_req); end
        rstn = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || enabled !== 1'b0) begin errors++; $display("FAIL late_ack got %b/%h/%b exp 1/0/0", imem_req, imem_addr, enabled); end
        tick();
        tick();
        checks++; if (dbg_state !== S_WAIT || enabled !== 1'b0) begin errors++; $display("FAIL late_ack_wait got %0d/%b exp %0d/0", dbg_state, enabled, S_WAIT); end
    endtask

    task automatic test_timeout();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        repeat (MW - 1) tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", fault); end
        tick();
        checks++; if (fault !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL to_fault got %b/%b exp 1/0", fault, imem_req); end
        next = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1;
        repeat (3) tick();
        next = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
        checks++; if (fault !== 1'b1 || enabled !== 1'b0 || imem_req !== 1'b0 || dbg_state !== S_FAULT) begin
            errors++; $display("FAIL to_sticky got %b/%b/%b/%0d exp 1/0/0/%0d", fault, enabled, imem_req, dbg_state, S_FAULT);
        end
        rstn = 1'b0;
        #1;
        checks++; if (fault !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL to_clear got %b/%h exp 0/0", fault, imem_addr); end
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_wrap();
        w_rstn = 1'b1;
        tick();
        checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %b/%h exp 1/fffffffc", w_imem_req, w_imem_addr); end
        tick();
        w_ack = 1'b1; w_rdata = 32'h0050_0293;
        tick();
        w_ack = 1'b0;
        checks++; if (w_enabled !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_instr_raw !== 32'h0050_0293) begin
            errors++; $display("FAIL wrap_issue got %b/%h/%h exp 1/fffffffc/00500293", w_enabled, w_pc, w_instr_raw);
        end
        tick();
        w_next = 1'b1;
        tick();
        w_next = 1'b0;
        checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %b/%h exp 1/0", w_imem_req, w_imem_addr); end
    endtask

    // Sequence of scenarios and final report.
    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect_wait();
        test_redirect_next();
        test_misalign();
        test_reset_mid();
        test_timeout();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
